// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Package  : serial_sub_pkg
// Purpose  : Shared state encoding and default width for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

  localparam int unsigned c_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/full_subtractor_1_bit.sv
// ============================================================================
// Module   : full_subtractor_1_bit
// Purpose  : Combinational one-bit full subtractor, d = a - b - bin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor_1_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor_1_bit

`default_nettype wire

// File: rtl/serial_subtractor_4_bit.sv
// ============================================================================
// Module   : serial_subtractor_4_bit
// Purpose  : Bit-serial D = A - B - Bin, LSB first, start/done handshake.
//            Define SUB_OVF_EN to add the signed-overflow output V.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor_4_bit
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_LAST_STEP = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic             bout_q;
  logic             diff_bit;
  logic             br_d;

`ifdef SUB_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic v_q;
  assign V = v_q;
`endif

  full_subtractor_1_bit u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (diff_bit),
    .bout (br_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            br_q    <= Bin;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
`ifdef SUB_OVF_EN
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
            v_q     <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          // Difference bits enter at the MSB so D is LSB-aligned after WIDTH steps.
          d_q   <= {diff_bit, d_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == c_LAST_STEP) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            bout_q  <= br_d;
`ifdef SUB_OVF_EN
            v_q     <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_bit);
`endif
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;

endmodule : serial_subtractor_4_bit

`default_nettype wire
